clock_mode_ctrl: RTL and testbench
==================================

// Module: clock_mode_ctrl
// PURPOSE
//  Mode sequencer for the MM:SS clock. Decodes debounced buttons and the adjust switch into RUN/PAUSE/ADJ_MIN/ADJ_SEC.
//  Turns divider ticks into increment strobes for the minute/second counter, and produces the digit blink mask.
//  Sits between the debouncers/clock dividers and the counter and seven-segment mux.
//  Replaces the ad-hoc select/blink logic in the top level.
// PARAMETERS
//  BLINK_TICKS  1        tick_blink pulses per blink half-period (1..15)
//  MIN_MASK     4'b1100  digits blanked while adjusting minutes (bit=1 blanks anode)
//  SEC_MASK     4'b0011  digits blanked while adjusting seconds
// PORTS
//  clk         in   1  system clock; only clock in the block
//  reset       in   1  synchronous, active-high reset
//  btn_pause   in   1  debounced pause button, level
//  btn_sel     in   1  debounced field-select button, level
//  adjust      in   1  adjust-mode switch, level
//  tick_run    in   1  1-cycle pulse at 1 Hz
//  tick_adj    in   1  1-cycle pulse at 2 Hz
//  tick_blink  in   1  1-cycle pulse at 4 Hz
//  sec_inc     out  1  1-cycle strobe: increment seconds
//  min_inc     out  1  1-cycle strobe: increment minutes
//  carry_en    out  1  1 = 59->00 seconds wrap carries into minutes
//  anode_mask  out  4  1 = force that anode off (OR into active-low anode)
//  mode        out  2  00 RUN, 01 PAUSE, 10 ADJ_MIN, 11 ADJ_SEC
// BEHAVIOUR
//  - Reset: mode=RUN; sec_inc=min_inc=0; carry_en=1; anode_mask=0; blink phase=0; blink count=0.
//    Edge-detect registers load the current btn levels, so a button held through reset is not a press.
//  - Press = level & ~prev_level; exactly one press per 0->1 edge, however long the button is held.
//  - FSM, evaluated every clk:
//    adjust=1 and mode in {RUN,PAUSE} -> ADJ_MIN.
//    adjust=0 and mode in {ADJ_MIN,ADJ_SEC} -> RUN.
//    RUN + pause press -> PAUSE; PAUSE + pause press -> RUN.
//    ADJ_MIN + sel press -> ADJ_SEC; ADJ_SEC + sel press -> ADJ_MIN.
//    Pause press is ignored in ADJ states. Sel press is ignored in RUN and PAUSE.
//    The adjust rule has priority over a same-cycle press.
//  - Strobes are registered, 1 cycle after the tick, and decided by the state in the tick cycle (pre-transition).
//    RUN: sec_inc on tick_run.
//    ADJ_SEC: sec_inc on tick_adj.
//    ADJ_MIN: min_inc on tick_adj.
//    PAUSE: no strobes; ticks are dropped, not queued.
//    sec_inc and min_inc are never high together.
//  - carry_en: registered; 1 in RUN/PAUSE, 0 in ADJ states, so second adjustment never disturbs minutes.
//  - Blink:
//    Counter counts tick_blink in ADJ states. When it reaches BLINK_TICKS it clears and the phase toggles.
//    Entering any ADJ state, or a MIN<->SEC switch, clears counter and phase, so the selected field shows immediately.
//    anode_mask = MIN_MASK (ADJ_MIN & phase), SEC_MASK (ADJ_SEC & phase), else 0; registered, 1-cycle latency.
//  - mode output = state register (0 latency from state).
//  - Reset mid-operation: the next cycle matches the reset values regardless of pending ticks or presses.
// TESTING
//  1 reset; 3 tick_run pulses -> 3 sec_inc pulses, each 1 cycle after its tick; min_inc=0; mode=00.
//  2 RUN, btn_pause held 100 cycles -> mode=01 once. tick_run then gives no sec_inc. Second press -> mode=00.
//  3 adjust=1 -> mode=10, carry_en=0. tick_adj -> min_inc only. btn_sel press -> mode=11, tick_adj -> sec_inc only.
//  4 ADJ_MIN, BLINK_TICKS=1: tick_blink x2 -> anode_mask 1100 then 0000. sel press -> mask 0000; next tick -> 0011.
//  5 Same cycle: adjust 1->0 + tick_adj in ADJ_SEC -> one sec_inc, mode=00; pause press + adjust=1 in RUN -> mode=10.
//  6 reset asserted in ADJ_SEC, phase=1 -> next cycle mode=00, anode_mask=0, carry_en=1, no strobes.

Source files
------------

// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl
//   Mode sequencer for the MM:SS clock. It decodes the debounced buttons and
//   the adjust switch into RUN / PAUSE / ADJ_MIN / ADJ_SEC. It turns divider
//   ticks into increment strobes for the minute/second counter, and it
//   produces the digit blink mask for the seven-segment mux.
//
// Ports
//   clk         in   1  system clock (only clock in the block)
//   reset       in   1  synchronous, active-high reset
//   btn_pause   in   1  debounced pause button, level
//   btn_sel     in   1  debounced field-select button, level
//   adjust      in   1  adjust-mode switch, level
//   tick_run    in   1  1-cycle pulse at 1 Hz
//   tick_adj    in   1  1-cycle pulse at 2 Hz
//   tick_blink  in   1  1-cycle pulse at 4 Hz
//   sec_inc     out  1  1-cycle strobe: increment seconds
//   min_inc     out  1  1-cycle strobe: increment minutes
//   carry_en    out  1  1 = 59->00 seconds wrap carries into minutes
//   anode_mask  out  4  1 = force that anode off
//   mode        out  2  00 RUN, 01 PAUSE, 10 ADJ_MIN, 11 ADJ_SEC
module clock_mode_ctrl #(
  parameter int unsigned BLINK_TICKS = 1,
  parameter logic [3:0]  MIN_MASK    = 4'b1100,
  parameter logic [3:0]  SEC_MASK    = 4'b0011
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_pause,
  input  logic       btn_sel,
  input  logic       adjust,
  input  logic       tick_run,
  input  logic       tick_adj,
  input  logic       tick_blink,
  output logic       sec_inc,
  output logic       min_inc,
  output logic       carry_en,
  output logic [3:0] anode_mask,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_PAUSE   = 2'b01,
    ST_ADJ_MIN = 2'b10,
    ST_ADJ_SEC = 2'b11
  } state_e;

  localparam logic [3:0] BLINK_LIMIT = 4'(BLINK_TICKS);

  state_e     state_q, state_d;
  logic       pause_prev_q, sel_prev_q;
  logic       pause_press, sel_press;
  logic [3:0] blink_cnt_q, blink_cnt_d;
  logic       phase_q, phase_d;
  logic       adj_next;
  logic       sec_inc_q, sec_inc_d;
  logic       min_inc_q, min_inc_d;
  logic       carry_en_q, carry_en_d;
  logic [3:0] mask_q, mask_d;

  // One press per rising edge, however long the button is held.
  assign pause_press = btn_pause & ~pause_prev_q;
  assign sel_press   = btn_sel   & ~sel_prev_q;

  // Next-state: the adjust switch overrides any same-cycle press.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (adjust)           state_d = ST_ADJ_MIN;
        else if (pause_press) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (adjust)           state_d = ST_ADJ_MIN;
        else if (pause_press) state_d = ST_RUN;
      end
      ST_ADJ_MIN: begin
        if (!adjust)          state_d = ST_RUN;
        else if (sel_press)   state_d = ST_ADJ_SEC;
      end
      ST_ADJ_SEC: begin
        if (!adjust)          state_d = ST_RUN;
        else if (sel_press)   state_d = ST_ADJ_MIN;
      end
      default:                state_d = ST_RUN;
    endcase
  end

  // Blink counter/phase. Any entry into an adjust state (including a
  // MIN<->SEC switch) restarts at phase 0 so the selected field is visible
  // straight away. Outside the adjust states both are held cleared.
  always_comb begin
    adj_next    = (state_d == ST_ADJ_MIN) || (state_d == ST_ADJ_SEC);
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (!adj_next || (state_d != state_q)) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (tick_blink) begin
      if (blink_cnt_q + 4'd1 == BLINK_LIMIT) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 4'd1;
      end
    end
  end

  // Strobes follow the state of the tick cycle; carry_en and the mask are
  // registered from the next state so they line up with the mode output.
  always_comb begin
    sec_inc_d  = ((state_q == ST_RUN) && tick_run) ||
                 ((state_q == ST_ADJ_SEC) && tick_adj);
    min_inc_d  = (state_q == ST_ADJ_MIN) && tick_adj;
    carry_en_d = ~adj_next;
    mask_d     = '0;
    if (phase_d) begin
      if (state_d == ST_ADJ_MIN)      mask_d = MIN_MASK;
      else if (state_d == ST_ADJ_SEC) mask_d = SEC_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      pause_prev_q <= btn_pause;
      sel_prev_q   <= btn_sel;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      sec_inc_q    <= 1'b0;
      min_inc_q    <= 1'b0;
      carry_en_q   <= 1'b1;
      mask_q       <= '0;
    end else begin
      state_q      <= state_d;
      pause_prev_q <= btn_pause;
      sel_prev_q   <= btn_sel;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      sec_inc_q    <= sec_inc_d;
      min_inc_q    <= min_inc_d;
      carry_en_q   <= carry_en_d;
      mask_q       <= mask_d;
    end
  end

  assign sec_inc    = sec_inc_q;
  assign min_inc    = min_inc_q;
  assign carry_en   = carry_en_q;
  assign anode_mask = mask_q;
  assign mode       = state_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
module tb_clock_mode_ctrl;

  localparam int unsigned BT = 1;
  localparam logic [3:0]  MM = 4'b1100;
  localparam logic [3:0]  SM = 4'b0011;

  logic       clk = 1'b0;
  logic       reset, btn_pause, btn_sel, adjust;
  logic       tick_run, tick_adj, tick_blink;
  logic       sec_inc, min_inc, carry_en;
  logic [3:0] anode_mask;
  logic [1:0] mode;

  int checks = 0;
  int failures = 0;

  // Reference model state (mode as integer 0..3)
  int m_mode, m_cnt, m_phase, m_prev_p, m_prev_s;
  int e_sec, e_min, e_carry, e_mask;

  always #5 clk = ~clk;

  clock_mode_ctrl #(
    .BLINK_TICKS(BT),
    .MIN_MASK   (MM),
    .SEC_MASK   (SM)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_pause (btn_pause),
    .btn_sel   (btn_sel),
    .adjust    (adjust),
    .tick_run  (tick_run),
    .tick_adj  (tick_adj),
    .tick_blink(tick_blink),
    .sec_inc   (sec_inc),
    .min_inc   (min_inc),
    .carry_en  (carry_en),
    .anode_mask(anode_mask),
    .mode      (mode)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Predict the outputs after the coming edge from the clock's rules.
  task automatic model(input int r, input int p, input int s, input int a,
                       input int tr, input int ta, input int tb);
    int pp, sp, nm;
    if (r != 0) begin
      m_mode = 0; m_cnt = 0; m_phase = 0;
      e_sec = 0; e_min = 0; e_carry = 1; e_mask = 0;
    end else begin
      pp = (p != 0 && m_prev_p == 0) ? 1 : 0;
      sp = (s != 0 && m_prev_s == 0) ? 1 : 0;
      e_sec = ((m_mode == 0 && tr != 0) || (m_mode == 3 && ta != 0)) ? 1 : 0;
      e_min = (m_mode == 2 && ta != 0) ? 1 : 0;
      nm = m_mode;
      if (a != 0 && m_mode < 2)       nm = 2;
      else if (a == 0 && m_mode >= 2) nm = 0;
      else if (m_mode < 2 && pp != 0) nm = 1 - m_mode;
      else if (m_mode >= 2 && sp != 0) nm = 5 - m_mode;
      if (nm < 2 || nm != m_mode) begin
        m_cnt = 0; m_phase = 0;
      end else if (tb != 0) begin
        m_cnt++;
        if (m_cnt == int'(BT)) begin m_cnt = 0; m_phase = 1 - m_phase; end
      end
      m_mode  = nm;
      e_carry = (nm < 2) ? 1 : 0;
      e_mask  = (m_phase == 0) ? 0 : (nm == 2) ? int'(MM) : (nm == 3) ? int'(SM) : 0;
    end
    m_prev_p = p;
    m_prev_s = s;
  endtask

  task automatic cyc(input int r, input int p, input int s, input int a,
                     input int tr, input int ta, input int tb);
    reset = 1'(r); btn_pause = 1'(p); btn_sel = 1'(s); adjust = 1'(a);
    tick_run = 1'(tr); tick_adj = 1'(ta); tick_blink = 1'(tb);
    model(r, p, s, a, tr, ta, tb);
    @(posedge clk);
    #1;
    chk("mode",       {2'b00, mode},       4'(m_mode));
    chk("sec_inc",    {3'b000, sec_inc},   4'(e_sec));
    chk("min_inc",    {3'b000, min_inc},   4'(e_min));
    chk("carry_en",   {3'b000, carry_en},  4'(e_carry));
    chk("anode_mask", anode_mask,          4'(e_mask));
    chk("exclusive",  {3'b000, sec_inc & min_inc}, 4'd0);
  endtask

  initial begin
    int p, s, a;
    // 1: reset, then three run ticks
    cyc(1,0,0,0,0,0,0);
    cyc(1,0,0,0,0,0,0);
    chk("rst_carry", {3'b000, carry_en}, 4'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(0,0,0,0,1,0,0);
      chk("t1_sec", {3'b000, sec_inc}, 4'd1);
      cyc(0,0,0,0,0,0,0);
      chk("t1_sec_off", {3'b000, sec_inc}, 4'd0);
    end
    // 2: held pause toggles once; paused ticks dropped
    for (int i = 0; i < 100; i++) cyc(0,1,0,0,0,0,0);
    chk("t2_pause", {2'b00, mode}, 4'd1);
    cyc(0,0,0,0,1,0,0);
    chk("t2_nosec", {3'b000, sec_inc}, 4'd0);
    cyc(0,1,0,0,0,0,0);
    chk("t2_run", {2'b00, mode}, 4'd0);
    cyc(0,0,0,0,0,0,0);
    // 3: adjust minutes then seconds
    cyc(0,0,0,1,0,0,0);
    chk("t3_adjmin", {2'b00, mode}, 4'd2);
    chk("t3_carry", {3'b000, carry_en}, 4'd0);
    cyc(0,0,0,1,0,1,0);
    chk("t3_min", {3'b000, min_inc}, 4'd1);
    cyc(0,0,1,1,0,0,0);
    chk("t3_adjsec", {2'b00, mode}, 4'd3);
    cyc(0,0,1,1,0,1,0);
    chk("t3_sec", {3'b000, sec_inc}, 4'd1);
    // 4: blink in ADJ_MIN, switch field resets phase
    cyc(0,0,0,1,0,0,0);
    cyc(0,0,1,1,0,0,0);
    cyc(0,0,1,1,0,0,1);
    chk("t4_mask1", anode_mask, 4'b1100);
    cyc(0,0,0,1,0,0,1);
    chk("t4_mask0", anode_mask, 4'b0000);
    cyc(0,0,0,1,0,0,1);
    cyc(0,0,1,1,0,0,0);
    chk("t4_sel_clr", anode_mask, 4'b0000);
    cyc(0,0,1,1,0,0,1);
    chk("t4_secmask", anode_mask, 4'b0011);
    // 5: same-cycle adjust drop + tick_adj; pause press + adjust
    cyc(0,0,0,0,0,1,0);
    chk("t5_sec", {3'b000, sec_inc}, 4'd1);
    chk("t5_run", {2'b00, mode}, 4'd0);
    cyc(0,1,0,1,0,0,0);
    chk("t5_adj", {2'b00, mode}, 4'd2);
    // 6: reset in ADJ_SEC with phase 1 and pending activity
    cyc(0,0,1,1,0,0,0);
    cyc(0,0,0,1,0,0,1);
    chk("t6_pre", anode_mask, 4'b0011);
    cyc(1,1,1,1,1,1,1);
    chk("t6_mode", {2'b00, mode}, 4'd0);
    chk("t6_mask", anode_mask, 4'd0);
    chk("t6_carry", {3'b000, carry_en}, 4'd1);
    // Randomised traffic against the model
    p = 1; s = 1; a = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0)  p = 1 - p;
      if ($urandom_range(5) == 0)  s = 1 - s;
      if ($urandom_range(39) == 0) a = 1 - a;
      cyc(($urandom_range(299) == 0) ? 1 : 0, p, s, a,
          ($urandom_range(3) == 0) ? 1 : 0,
          ($urandom_range(3) == 0) ? 1 : 0,
          ($urandom_range(2) == 0) ? 1 : 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
